lzc_dec: RTL and testbench

LZC_DEC -- requirements
Module: lzc_dec

---
 rtl/lzc_pkg.sv | 26 ++
 rtl/lzc_dec_core.sv | 33 +++
 rtl/lzc_dec.sv | 140 ++++++++++++++
 tb/tb_lzc_dec.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lzc_pkg.sv
// Shared types for the trailing-zero-count decoder: output mode,
// decoded entry record and handshake FSM states.
package lzc_pkg;

    // Upper bound on the decoded vector width carried in an entry record.
    // Instances use the low WIDTH bits; the remaining bits are always zero.
    localparam int LZC_MAX_WIDTH = 32;

    typedef enum logic {
        MODE_ONEHOT = 1'b0,
        MODE_THERMO = 1'b1
    } lzc_mode_e;

    typedef struct packed {
        logic [LZC_MAX_WIDTH-1:0] vec;
        logic                     err;
    } lzc_entry_t;

    // Occupancy of the two-entry output buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } lzc_state_e;

endpackage

// File: rtl/lzc_dec_core.sv
// Combinational decoder: turns a trailing-zero count into a one-hot or
// thermometer vector and flags out-of-range counts. WIDTH must not
// exceed LZC_MAX_WIDTH.
module lzc_dec_core
    import lzc_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = $clog2(WIDTH)
) (
    input  logic [CNT_WIDTH-1:0] i_cnt,
    input  logic                 i_empty,
    input  lzc_mode_e            i_mode,
    output lzc_entry_t           o_entry
);

    // Decode count to vector; empty tokens and bad counts yield all zeros.
    always_comb begin
        // NOTE: assigning a default to every output first guarantees no
        // latch is inferred on paths that leave some bits unassigned.
        o_entry = '0;
        if (!i_empty) begin
            if (int'(i_cnt) >= WIDTH) begin
                o_entry.err = 1'b1;
            end else begin
                for (int i = 0; i < WIDTH; i++) begin
                    o_entry.vec[i] = (i_mode == MODE_ONEHOT) ? (i == int'(i_cnt))
                                                             : (i >= int'(i_cnt));
                end
            end
        end
    end

endmodule

// File: rtl/lzc_dec.sv
// Trailing-zero-count decoder with a two-entry (main + skid) output
// buffer. Tokens are decoded on capture and appear one cycle later;
// in_ready_o is a flop so out_ready_i never reaches it combinationally.
module lzc_dec
    import lzc_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = $clog2(WIDTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [CNT_WIDTH-1:0] cnt_i,
    input  logic                 empty_i,
    input  logic                 mode_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [WIDTH-1:0]     vec_o,
    output logic                 err_o,
    output logic [7:0]           empty_cnt_o
);

    lzc_state_e r_state;
    lzc_state_e w_next_state;
    logic       r_in_ready;
    lzc_entry_t r_main;
    lzc_entry_t r_skid;
    lzc_entry_t w_dec;
    logic [7:0] r_empty_cnt;

    logic w_accept;
    logic w_deliver;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    lzc_dec_core #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_core (
        .i_cnt   (cnt_i),
        .i_empty (empty_i),
        .i_mode  (lzc_mode_e'(mode_i)),
        .o_entry (w_dec)
    );

    assign w_accept  = in_valid_i && r_in_ready;
    assign w_deliver = (r_state != ST_EMPTY) && out_ready_i;

    // Next occupancy and which entry register loads this cycle.
    always_comb begin
        w_next_state     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_next_state   = ST_ONE;
                    w_load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_deliver) begin
                    w_load_main_in = 1'b1;
                end else if (w_accept) begin
                    w_next_state = ST_FULL;
                    w_load_skid  = 1'b1;
                end else if (w_deliver) begin
                    w_next_state = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready_o is low here, so only the output side moves.
                if (w_deliver) begin
                    w_next_state     = ST_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: w_next_state = ST_EMPTY;
        endcase
    end

    // State register; ready is registered from the next occupancy.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        if (rst_i) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != ST_FULL);
        end
    end

    // Entry registers: main feeds the outputs, skid parks a stalled token.
    always_ff @(posedge clk_i) begin
        // NOTE: the data entries are reset too, because the cleared
        // vec_o/err_o values are architecturally visible after reset.
        if (rst_i) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main <= w_dec;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_dec;
            end
        end
    end

    // Saturating count of accepted empty tokens.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_empty_cnt <= '0;
        end else if (w_accept && empty_i && (r_empty_cnt != 8'hFF)) begin
            r_empty_cnt <= r_empty_cnt + 8'd1;
        end
    end

    // Pad bits above WIDTH are constant zero and intentionally dropped.
    generate
        if (WIDTH < LZC_MAX_WIDTH) begin : g_pad
            logic w_unused_pad;
            assign w_unused_pad = ^r_main.vec[LZC_MAX_WIDTH-1:WIDTH];
        end
    endgenerate

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = (r_state != ST_EMPTY);
    assign vec_o       = r_main.vec[WIDTH-1:0];
    assign err_o       = r_main.err;
    assign empty_cnt_o = r_empty_cnt;

endmodule

// File: tb/tb_lzc_dec.sv
// Directed bench for lzc_dec: table-driven decode vectors at WIDTH=4,
// out-of-range cases at WIDTH=5, then backpressure, reset-while-full
// and empty-counter saturation sequences.
module tb_lzc_dec;

    logic       clk;
    logic       rst;

    // WIDTH=4 instance
    logic       in_valid;
    logic       in_ready;
    logic [1:0] cnt;
    logic       empty;
    logic       mode;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] vec;
    logic       err;
    logic [7:0] empty_cnt;

    // WIDTH=5 instance
    logic       v5_in_valid;
    logic       v5_in_ready;
    logic [2:0] v5_cnt;
    logic       v5_empty;
    logic       v5_mode;
    logic       v5_out_valid;
    logic       v5_out_ready;
    logic [4:0] v5_vec;
    logic       v5_err;
    logic [7:0] v5_empty_cnt;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       mode;
        logic       empty;
        logic [1:0] cnt;
        logic [3:0] exp_vec;
        logic       exp_err;
    } vec_rec_t;

    vec_rec_t tbl [10];

    lzc_dec #(.WIDTH(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .cnt_i       (cnt),
        .empty_i     (empty),
        .mode_i      (mode),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .vec_o       (vec),
        .err_o       (err),
        .empty_cnt_o (empty_cnt)
    );

    lzc_dec #(.WIDTH(5)) dut5 (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (v5_in_valid),
        .in_ready_o  (v5_in_ready),
        .cnt_i       (v5_cnt),
        .empty_i     (v5_empty),
        .mode_i      (v5_mode),
        .out_valid_o (v5_out_valid),
        .out_ready_i (v5_out_ready),
        .vec_o       (v5_vec),
        .err_o       (v5_err),
        .empty_cnt_o (v5_empty_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic m, input logic e, input logic [1:0] c);
        in_valid = v;
        mode     = m;
        empty    = e;
        cnt      = c;
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b0, 2'd0, 4'b0001, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 2'd1, 4'b0010, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 2'd2, 4'b0100, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 2'd3, 4'b1000, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 2'd1, 4'b1110, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 2'd3, 4'b1000, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 2'd2, 4'b0000, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 2'd0, 4'b1111, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 2'd3, 4'b0000, 1'b0};
        tbl[9] = '{1'b1, 1'b0, 2'd2, 4'b1100, 1'b0};

        rst          = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'd0);
        out_ready    = 1'b1;
        v5_in_valid  = 1'b0;
        v5_cnt       = 3'd0;
        v5_empty     = 1'b0;
        v5_mode      = 1'b0;
        v5_out_ready = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_vec", 32'(vec), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_empty_cnt", 32'(empty_cnt), 32'd0);
        rst = 1'b0;

        // Back-to-back table vectors, one output per cycle
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, tbl[i].mode, tbl[i].empty, tbl[i].cnt);
            tick();
            check($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("tbl%0d_vec", i), 32'(vec), 32'(tbl[i].exp_vec));
            check($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
            check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'd1);
        end
        drive(1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        check("tbl_drain_out_valid", 32'(out_valid), 32'd0);
        check("tbl_empty_cnt", 32'(empty_cnt), 32'd2);

        // WIDTH=5: out-of-range counts and wide decodes
        v5_in_valid = 1'b1; v5_mode = 1'b0; v5_empty = 1'b0; v5_cnt = 3'd6;
        tick();
        check("w5_cnt6_out_valid", 32'(v5_out_valid), 32'd1);
        check("w5_cnt6_vec", 32'(v5_vec), 32'd0);
        check("w5_cnt6_err", 32'(v5_err), 32'd1);
        v5_cnt = 3'd4;
        tick();
        check("w5_onehot4_vec", 32'(v5_vec), 32'b10000);
        check("w5_onehot4_err", 32'(v5_err), 32'd0);
        v5_mode = 1'b1; v5_cnt = 3'd1;
        tick();
        check("w5_thermo1_vec", 32'(v5_vec), 32'b11110);
        v5_cnt = 3'd5;
        tick();
        check("w5_thermo5_vec", 32'(v5_vec), 32'd0);
        check("w5_thermo5_err", 32'(v5_err), 32'd1);
        v5_empty = 1'b1; v5_cnt = 3'd7;
        tick();
        check("w5_empty_vec", 32'(v5_vec), 32'd0);
        check("w5_empty_err", 32'(v5_err), 32'd0);
        v5_in_valid = 1'b0;
        tick();
        check("w5_drain_out_valid", 32'(v5_out_valid), 32'd0);
        check("w5_empty_cnt", 32'(v5_empty_cnt), 32'd1);
        check("w5_in_ready", 32'(v5_in_ready), 32'd1);

        // Backpressure: A, B accepted, C refused until release
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 2'd1);           // A -> 0010
        tick();
        check("bp_a_out_valid", 32'(out_valid), 32'd1);
        check("bp_a_vec", 32'(vec), 32'b0010);
        check("bp_a_in_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 2'd2);           // B -> 0100
        tick();
        check("bp_full_in_ready", 32'(in_ready), 32'd0);
        check("bp_full_vec_hold", 32'(vec), 32'b0010);
        drive(1'b1, 1'b1, 1'b0, 2'd2);           // C -> 1100
        tick();
        check("bp_c_refused_in_ready", 32'(in_ready), 32'd0);
        check("bp_stall_vec_hold", 32'(vec), 32'b0010);
        check("bp_stall_valid_hold", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        check("bp_b_vec", 32'(vec), 32'b0100);
        check("bp_b_out_valid", 32'(out_valid), 32'd1);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp_c_vec", 32'(vec), 32'b1100);
        check("bp_c_out_valid", 32'(out_valid), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        check("bp_drain_out_valid", 32'(out_valid), 32'd0);

        // Reset while FULL discards both entries and the offered token
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 2'd0);           // empty token
        tick();
        drive(1'b1, 1'b0, 1'b0, 2'd3);
        tick();
        check("rf_full_in_ready", 32'(in_ready), 32'd0);
        check("rf_pre_empty_cnt", 32'(empty_cnt), 32'd3);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 2'd0);           // offered during reset
        tick();
        check("rf_out_valid", 32'(out_valid), 32'd0);
        check("rf_in_ready", 32'(in_ready), 32'd1);
        check("rf_empty_cnt", 32'(empty_cnt), 32'd0);
        check("rf_vec", 32'(vec), 32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rf_no_stale%0d", i), 32'(out_valid), 32'd0);
        end
        check("rf_post_empty_cnt", 32'(empty_cnt), 32'd0);

        // Saturation of the empty-token counter
        drive(1'b1, 1'b0, 1'b1, 2'd0);
        for (int n = 1; n <= 300; n++) begin
            tick();
            if (n == 100) check("sat_100", 32'(empty_cnt), 32'd100);
            if (n == 255) check("sat_255", 32'(empty_cnt), 32'd255);
        end
        check("sat_300", 32'(empty_cnt), 32'd255);
        check("sat_vec", 32'(vec), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        check("sat_hold", 32'(empty_cnt), 32'd255);
        check("sat_drain_out_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
